// File: rtl/probe_trigger_controller_if.sv
// Purpose: bundles the probe controller's control inputs and probe-facing outputs.
// Latency: none (wires only).
// Backpressure: none; all signals are plain levels/pulses, no handshake.
// Ports: master = board/control side (drives arm/abort/config/dataIn),
//        slave  = controller side (drives start/sample/armed/capturing/done).
interface probe_trigger_controller_if #(
  parameter int LOG2_OF_NUMBER_OF_CHANNELS = 2,
  parameter int DIVIDER_WIDTH              = 22,
  parameter int TIMEOUT_WIDTH              = 16
);
  localparam int NCH = 2 ** LOG2_OF_NUMBER_OF_CHANNELS;

  logic                     arm;
  logic                     abort;
  logic [DIVIDER_WIDTH-1:0] divider;
  logic [NCH-1:0]           dataIn;
  logic [NCH-1:0]           triggerMask;
  logic [NCH-1:0]           triggerValue;
  logic                     edgeMode;
  logic [TIMEOUT_WIDTH-1:0] timeout;
  logic                     start;
  logic                     sample;
  logic                     armed;
  logic                     capturing;
  logic                     done;

  modport master (
    output arm, abort, divider, dataIn, triggerMask, triggerValue, edgeMode, timeout,
    input  start, sample, armed, capturing, done
  );

  modport slave (
    input  arm, abort, divider, dataIn, triggerMask, triggerValue, edgeMode, timeout,
    output start, sample, armed, capturing, done
  );
endinterface

// File: rtl/probe_trigger_controller.sv
// Purpose: logic-analyzer probe sequencer: sample-rate divider, arm, mask/value trigger, one-buffer capture gate.
// Latency: trigger tick at cycle T -> start at T+1; sample is the same-cycle gate of the registered tick.
// Backpressure: none; abort wins over everything and forces start/sample low in its own cycle.
// Ports: clk, resetN (async active-low); bus (slave modport) carries arm/abort pulses, divider,
//        dataIn/triggerMask/triggerValue/edgeMode, timeout, and outputs start/sample/armed/capturing/done.
// Optional: define PROBE_TRIGGER_TIMEOUT_EN to auto-fire after 'timeout' ticks in ARMED (0 disables).
module probe_trigger_controller #(
  parameter int LOG2_OF_NUMBER_OF_CHANNELS = 2,
  parameter int LOG2_OF_NUMBER_OF_SAMPLES  = 12,
  parameter int DIVIDER_WIDTH              = 22,
  parameter int TIMEOUT_WIDTH              = 16
) (
  input logic                          clk,
  input logic                          resetN,
  probe_trigger_controller_if.slave    bus
);
  localparam int NCH = 2 ** LOG2_OF_NUMBER_OF_CHANNELS;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                           state, state_nxt;
  logic [DIVIDER_WIDTH-1:0]         div_cnt;
  logic                             tick;
  logic                             prev_match, prev_match_nxt;
  logic [LOG2_OF_NUMBER_OF_SAMPLES-1:0] smp_cnt, smp_cnt_nxt;
  logic                             start_q, start_nxt;
  logic                             armed_q, capturing_q, done_q;
  logic [NCH-1:0]                   mismatch;
  logic                             match;
  logic                             fire;
  logic                             fwd;
  logic                             force_fire;

  // Divider: tick is registered, so it lands one cycle after the counter hits
  // 'divider'. Lowering divider below the running count lets the counter wrap
  // through its maximum; that is accepted behaviour.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= (div_cnt == bus.divider);
      if (div_cnt == bus.divider) div_cnt <= '0;
      else                        div_cnt <= div_cnt + DIVIDER_WIDTH'(1);
    end
  end

  // Channels with mask 0 never disqualify a match; all-zero mask always matches.
  assign mismatch = (bus.dataIn ^ bus.triggerValue) & bus.triggerMask;
  assign match    = (mismatch == '0);

  // A strobe is forwarded only while capturing and never in an abort cycle.
  assign fwd = tick && (state == S_CAPTURE) && !bus.abort;

`ifdef PROBE_TRIGGER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt;

  // Counter sits at zero outside ARMED, so it is already clear on entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                   to_cnt <= '0;
    else if (state != S_ARMED)     to_cnt <= '0;
    else if (tick)                 to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
  end

  assign force_fire = (state == S_ARMED) && tick && (bus.timeout != '0) &&
                      ((to_cnt + TIMEOUT_WIDTH'(1)) == bus.timeout);
`else
  logic [TIMEOUT_WIDTH-1:0] unused_timeout;
  assign unused_timeout = bus.timeout;
  assign force_fire     = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    prev_match_nxt = prev_match;
    smp_cnt_nxt    = smp_cnt;
    start_nxt      = 1'b0;
    fire           = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.arm) begin
          state_nxt      = S_ARMED;
          prev_match_nxt = 1'b1;  // an already-matching input must not edge-fire
        end
      end
      S_ARMED: begin
        if (tick) begin
          fire           = bus.edgeMode ? (match && !prev_match) : match;
          prev_match_nxt = match;
        end
        // The firing tick itself is consumed here and not forwarded to sample.
        if (fire || force_fire) begin
          state_nxt   = S_CAPTURE;
          start_nxt   = 1'b1;
          smp_cnt_nxt = '0;
        end
      end
      S_CAPTURE: begin
        if (fwd) begin
          smp_cnt_nxt = smp_cnt + 1'b1;
          if (smp_cnt == '1) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.arm) begin
          state_nxt      = S_ARMED;
          prev_match_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) begin
      state_nxt = S_IDLE;
      start_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      prev_match  <= 1'b1;
      smp_cnt     <= '0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_match  <= prev_match_nxt;
      smp_cnt     <= smp_cnt_nxt;
      start_q     <= start_nxt;
      armed_q     <= (state_nxt == S_ARMED);
      capturing_q <= (state_nxt == S_CAPTURE);
      done_q      <= (state_nxt == S_DONE);
    end
  end

  assign bus.start     = start_q && !bus.abort;
  assign bus.sample    = fwd;
  assign bus.armed     = armed_q;
  assign bus.capturing = capturing_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_probe_trigger_controller.sv
module tb_probe_trigger_controller;
  localparam int LCH  = 2;
  localparam int LSMP = 12;
  localparam int DW   = 22;
  localparam int TW   = 16;
  localparam int NCH  = 1 << LCH;
  localparam int NSMP = 1 << LSMP;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  probe_trigger_controller_if #(.LOG2_OF_NUMBER_OF_CHANNELS(LCH), .DIVIDER_WIDTH(DW),
                                .TIMEOUT_WIDTH(TW)) bus ();

  probe_trigger_controller #(.LOG2_OF_NUMBER_OF_CHANNELS(LCH), .LOG2_OF_NUMBER_OF_SAMPLES(LSMP),
                             .DIVIDER_WIDTH(DW), .TIMEOUT_WIDTH(TW))
    dut (.clk(clk), .resetN(resetN), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  // Capture is tracked as "strobes still owed" rather than as a state machine.
  int m_cnt;      // divider count as it stands in the current cycle
  bit m_tick;     // strobe due this cycle
  bit m_armed, m_done, m_first, m_prev;
  int m_left;     // >0 while capturing
  int m_to;       // ticks seen while armed

  function automatic void model_reset();
    m_cnt = 0; m_tick = 0; m_armed = 0; m_done = 0; m_first = 0;
    m_prev = 1; m_left = 0; m_to = 0;
  endfunction

  function automatic void model_step();
    bit match, fire, smp, nt;
    match = (((bus.dataIn ^ bus.triggerValue) & bus.triggerMask) == 0);
    smp   = (m_left > 0) && m_tick && !bus.abort;
    nt    = (m_cnt == int'(bus.divider));
    if (bus.abort) begin
      m_armed = 0; m_left = 0; m_done = 0; m_first = 0;
    end else begin
      m_first = 0;
      if (m_armed) begin
        fire = 0;
        if (m_tick) begin
          fire   = bus.edgeMode ? (match && !m_prev) : match;
          m_prev = match;
`ifdef PROBE_TRIGGER_TIMEOUT_EN
          m_to++;
          if (bus.timeout != 0 && m_to == int'(bus.timeout)) fire = 1;
`endif
        end
        if (fire) begin
          m_armed = 0; m_left = NSMP; m_first = 1;
        end
      end else if (m_left > 0) begin
        if (smp) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (bus.arm) begin
        m_armed = 1; m_prev = 1; m_done = 0; m_to = 0;
      end
    end
    m_tick = nt;
    m_cnt  = nt ? 0 : (m_cnt + 1) % (1 << DW);
  endfunction

  // One compare per cycle, mid-cycle, then advance the model.
  logic [4:0] exp_v;
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetN) model_reset();
      exp_v = {m_first && !bus.abort, (m_left > 0) && m_tick && !bus.abort,
               m_armed, m_left > 0, m_done};
      check("cycle {start,sample,armed,capturing,done}",
            int'({bus.start, bus.sample, bus.armed, bus.capturing, bus.done}), int'(exp_v));
      if (resetN) model_step();
    end
  end

  // Strobe monitor for the literal checks.
  int cyc = 0, last_smp = 0, mon_samples = 0, mon_starts = 0, mon_badgap = 0, mon_gap = 1;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.sample) begin
        if (mon_samples > 0 && (cyc - last_smp) != mon_gap) mon_badgap++;
        last_smp = cyc;
        mon_samples++;
      end
      if (bus.start) mon_starts++;
    end
  end

  // ---------------- driver ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; step(1); bus.arm = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; step(1); bus.abort = 1'b0;
  endtask

  // Only change divider when the running count is not above it, so no long wrap.
  task automatic set_div(int d);
    int guard;
    guard = 0;
    while (m_cnt > d && guard < 64) begin step(1); guard++; end
    bus.divider = DW'(d);
  endtask

  task automatic wait_done(int bound, string nm);
    int k;
    k = 0;
    while (!bus.done && k < bound) begin step(1); k++; end
    check(nm, int'(bus.done), 1);
  endtask

  task automatic mon_clear(int gap);
    mon_samples = 0; mon_starts = 0; mon_badgap = 0; mon_gap = gap;
  endtask

  int s0, d, found;

  initial begin
    resetN = 1'b0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.divider = DW'(3);
    bus.dataIn = '0; bus.triggerMask = '0; bus.triggerValue = '0;
    bus.edgeMode = 1'b0; bus.timeout = '0;
    step(3);
    @(negedge clk);
    check("reset outputs", int'({bus.start, bus.sample, bus.armed, bus.capturing, bus.done}), 0);
    step(1);
    resetN = 1'b1;
    step(5);

    // Divider 3, mask 0: one start, 4096 strobes exactly 4 clk apart; arm mid-capture ignored.
    mon_clear(4);
    pulse_arm();
    step(100);
    check("capturing mid-run", int'(bus.capturing), 1);
    pulse_arm();
    wait_done(20000, "div3 done reached");
    check("div3 sample count", mon_samples, NSMP);
    check("div3 start count", mon_starts, 1);
    check("div3 sample spacing errors", mon_badgap, 0);

    // abort + arm together in DONE -> IDLE.
    bus.arm = 1'b1; bus.abort = 1'b1; step(1); bus.arm = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abort+arm in done status", int'({bus.armed, bus.capturing, bus.done}), 0);
    s0 = mon_starts;
    step(20);
    check("no start after abort", mon_starts, s0);

    // Level trigger: mask 0011, value 0001; 0000 mismatches, 1101 matches.
    set_div(0);
    bus.triggerMask = 4'b0011; bus.triggerValue = 4'b0001; bus.dataIn = 4'b0000;
    bus.edgeMode = 1'b0;
    pulse_arm();
    step(5);
    check("level armed waiting", int'({bus.armed, bus.start}), 2);
    bus.dataIn = 4'b1101;
    @(negedge clk);
    check("level no start on trigger tick", int'(bus.start), 0);
    step(1);
    @(negedge clk);
    check("level start one cycle later", int'({bus.start, bus.capturing}), 3);
    step(1);
    pulse_abort();
    @(negedge clk);
    check("abort during capture", int'({bus.armed, bus.capturing, bus.done}), 0);
    step(1);

    // Edge trigger: already matching at arm must not fire.
    bus.edgeMode = 1'b1; bus.triggerMask = 4'b1111; bus.triggerValue = 4'b1010;
    bus.dataIn = 4'b1010;
    mon_clear(1);
    pulse_arm();
    step(10);
    check("edge no fire on held match", mon_starts, 0);
    check("edge still armed", int'(bus.armed), 1);
    bus.dataIn = 4'b0000;
    step(1);
    bus.dataIn = 4'b1010;
    @(negedge clk);
    check("edge no start on rising tick", int'(bus.start), 0);
    step(1);
    @(negedge clk);
    check("edge start after rise", int'(bus.start), 1);
    step(1);
    wait_done(6000, "edge done reached");
    check("edge sample count", mon_samples, NSMP);
    check("edge sample spacing errors", mon_badgap, 0);

    // Async reset mid-capture with divider 3.
    set_div(3);
    bus.edgeMode = 1'b0; bus.triggerMask = '0;
    pulse_arm();
    step(50);
    resetN = 1'b0;
    #1;
    check("async reset outputs", int'({bus.start, bus.sample, bus.armed, bus.capturing, bus.done}), 0);
    step(3);
    resetN = 1'b1;
    mon_clear(4);
    step(40);
    check("no sample after reset", mon_samples, 0);
    check("idle after reset", int'({bus.armed, bus.capturing, bus.done}), 0);
    pulse_arm();
    step(20);
    check("start after re-arm", mon_starts, 1);
    pulse_abort();

`ifdef PROBE_TRIGGER_TIMEOUT_EN
    // Auto-fire: timeout 5, divider 0, never matching.
    set_div(0);
    bus.triggerMask = 4'b1111; bus.triggerValue = 4'b0000; bus.dataIn = 4'b1111;
    bus.timeout = TW'(5);
    step(2);
    pulse_arm();
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.start && found == 0) found = k;
      step(1);
    end
    check("timeout start cycle after arm", found, 6);
    pulse_abort();
    bus.timeout = '0;
    mon_clear(1);
    pulse_arm();
    step(1000);
    check("timeout 0 never fires", mon_starts, 0);
    pulse_abort();
`endif

    // Randomized phase, checked cycle-by-cycle against the model.
    for (int c = 0; c < 20000; c++) begin
      bus.dataIn = NCH'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        bus.triggerMask  = NCH'($urandom);
        bus.triggerValue = NCH'($urandom);
        bus.edgeMode     = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 999) == 0) begin
        d = $urandom_range(0, 2);
        if (m_cnt <= d) bus.divider = DW'(d);
      end
      bus.arm   = ($urandom_range(0, 39) == 0);
      bus.abort = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    bus.arm = 1'b0; bus.abort = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
